// File: rtl/nmea_fixed_parse.sv
// Streaming parser for one NMEA decimal field: consumes ASCII characters and
// produces an unsigned fixed-point value scaled by 10^FRAC_DIGITS with error flags.
module nmea_fixed_parse #(
  parameter int FRAC_DIGITS = 1,
  parameter int OUT_W       = 16,
  parameter int MAX_CHARS   = 8,
  parameter int ROUND       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [OUT_W-1:0] value,
  output logic             out_valid,
  output logic             err_char,
  output logic             err_len,
  output logic             err_ovf,
  output logic             err_empty
);

  localparam int ACC_W = OUT_W + 4;
  localparam int FC_W  = $clog2(FRAC_DIGITS + 2);
  localparam int CC_W  = $clog2(MAX_CHARS + 2);
  localparam logic [ACC_W-1:0] SAT = {{4{1'b0}}, {OUT_W{1'b1}}};
  localparam logic [FC_W-1:0]  FD  = FC_W'(FRAC_DIGITS);
  localparam logic [CC_W-1:0]  MC  = CC_W'(MAX_CHARS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INT   = 3'd1,
    FRAC  = 3'd2,
    PAD   = 3'd3,
    FINAL = 3'd4
  } state_t;

  // acc*10 + d; acc never exceeds SAT when called, so the result fits in ACC_W
  function automatic logic [ACC_W-1:0] mac10(input logic [ACC_W-1:0] a, input logic [3:0] d);
    mac10 = (a << 3) + (a << 1) + {{(ACC_W-4){1'b0}}, d};
  endfunction

  state_t            state_r, state_s;
  logic [ACC_W-1:0]  acc_r, acc_s;
  logic [FC_W-1:0]   frac_cnt_r, frac_cnt_s;
  logic [CC_W-1:0]   char_cnt_r, char_cnt_s;
  logic [3:0]        rnd_digit_r, rnd_digit_s;
  logic              rnd_seen_r, rnd_seen_s;
  logic              seen_r, seen_s;
  logic              bad_char_r, bad_char_s;
  logic              too_long_r, too_long_s;
  logic              ovf_r, ovf_s;
  logic [OUT_W-1:0]  value_r, value_s;
  logic              out_valid_r, out_valid_s;
  logic              err_char_r, err_char_s;
  logic              err_len_r, err_len_s;
  logic              err_ovf_r, err_ovf_s;
  logic              err_empty_r, err_empty_s;
  logic              beat_s;
  logic              is_dig_s;
  logic              is_dot_s;
  logic [3:0]        dig_s;
  logic [ACC_W-1:0]  grow_s;
  logic [ACC_W-1:0]  acc_fin_s;
  logic              rnd_add_s;

  assign in_ready  = rst_n && !abort && (state_r == IDLE || state_r == INT || state_r == FRAC);
  assign value     = value_r;
  assign out_valid = out_valid_r;
  assign err_char  = err_char_r;
  assign err_len   = err_len_r;
  assign err_ovf   = err_ovf_r;
  assign err_empty = err_empty_r;

  // Next-state, datapath and result computation
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    frac_cnt_s  = frac_cnt_r;
    char_cnt_s  = char_cnt_r;
    rnd_digit_s = rnd_digit_r;
    rnd_seen_s  = rnd_seen_r;
    seen_s      = seen_r;
    bad_char_s  = bad_char_r;
    too_long_s  = too_long_r;
    ovf_s       = ovf_r;
    value_s     = value_r;
    out_valid_s = 1'b0;
    err_char_s  = err_char_r;
    err_len_s   = err_len_r;
    err_ovf_s   = err_ovf_r;
    err_empty_s = err_empty_r;
    beat_s      = in_valid && in_ready;
    is_dig_s    = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_dot_s    = (in_data == 8'h2E);
    dig_s       = in_data[3:0];
    grow_s      = mac10(acc_r, (state_r == PAD) ? 4'd0 : dig_s);

    case (state_r)
      IDLE, INT, FRAC: begin
        if (beat_s) begin
          if (in_last) begin
            if (!seen_r) begin
              state_s = FINAL;
            end else if (frac_cnt_r < FD) begin
              state_s = PAD;
            end else begin
              state_s = FINAL;
            end
          end else if (char_cnt_r >= MC) begin
            char_cnt_s = MC + {{(CC_W-1){1'b0}}, 1'b1};
            too_long_s = 1'b1;
          end else begin
            char_cnt_s = char_cnt_r + {{(CC_W-1){1'b0}}, 1'b1};
            if (is_dig_s) begin
              seen_s = 1'b1;
              if (state_r != FRAC || frac_cnt_r < FD) begin
                if (!ovf_r) begin
                  acc_s = grow_s;
                  ovf_s = (grow_s > SAT);
                end else begin
                  acc_s = acc_r;
                end
                if (state_r == FRAC) begin
                  frac_cnt_s = frac_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
                end else begin
                  state_s = INT;
                end
              end else if (!rnd_seen_r) begin
                rnd_digit_s = dig_s;
                rnd_seen_s  = 1'b1;
              end else begin
                rnd_digit_s = rnd_digit_r;
              end
            end else if (is_dot_s && state_r != FRAC) begin
              state_s = FRAC;
            end else begin
              // illegal character: flag it and keep parsing until the terminator
              bad_char_s = 1'b1;
              state_s    = (state_r == IDLE) ? INT : state_r;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      PAD: begin
        frac_cnt_s = frac_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
        if (!ovf_r) begin
          acc_s = grow_s;
          ovf_s = (grow_s > SAT);
        end else begin
          acc_s = acc_r;
        end
        if (frac_cnt_s == FD) begin
          state_s = FINAL;
        end else begin
          state_s = PAD;
        end
      end
      FINAL: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (abort || state_r == FINAL) begin
      state_s     = IDLE;
      acc_s       = '0;
      frac_cnt_s  = '0;
      char_cnt_s  = '0;
      rnd_digit_s = 4'd0;
      rnd_seen_s  = 1'b0;
      seen_s      = 1'b0;
      bad_char_s  = 1'b0;
      too_long_s  = 1'b0;
      ovf_s       = 1'b0;
    end else begin
      state_s = state_s;
    end

    rnd_add_s = (ROUND != 0) && (rnd_digit_s >= 4'd5);
    acc_fin_s = acc_s + {{(ACC_W-1){1'b0}}, rnd_add_s};

    // the result registers load on the edge that enters FINAL, so they are valid during FINAL
    if (state_s == FINAL) begin
      out_valid_s = 1'b1;
      err_char_s  = bad_char_s;
      err_len_s   = too_long_s;
      err_empty_s = !seen_s;
      if (bad_char_s || too_long_s) begin
        value_s   = '0;
        err_ovf_s = 1'b0;
      end else if (ovf_s || acc_fin_s > SAT) begin
        value_s   = SAT[OUT_W-1:0];
        err_ovf_s = 1'b1;
      end else begin
        value_s   = acc_fin_s[OUT_W-1:0];
        err_ovf_s = 1'b0;
      end
    end else if (abort || (state_r == IDLE && beat_s)) begin
      err_char_s  = 1'b0;
      err_len_s   = 1'b0;
      err_ovf_s   = 1'b0;
      err_empty_s = 1'b0;
    end else begin
      value_s = value_r;
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      frac_cnt_r  <= '0;
      char_cnt_r  <= '0;
      rnd_digit_r <= 4'd0;
      rnd_seen_r  <= 1'b0;
      seen_r      <= 1'b0;
      bad_char_r  <= 1'b0;
      too_long_r  <= 1'b0;
      ovf_r       <= 1'b0;
      value_r     <= '0;
      out_valid_r <= 1'b0;
      err_char_r  <= 1'b0;
      err_len_r   <= 1'b0;
      err_ovf_r   <= 1'b0;
      err_empty_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      frac_cnt_r  <= frac_cnt_s;
      char_cnt_r  <= char_cnt_s;
      rnd_digit_r <= rnd_digit_s;
      rnd_seen_r  <= rnd_seen_s;
      seen_r      <= seen_s;
      bad_char_r  <= bad_char_s;
      too_long_r  <= too_long_s;
      ovf_r       <= ovf_s;
      value_r     <= value_s;
      out_valid_r <= out_valid_s;
      err_char_r  <= err_char_s;
      err_len_r   <= err_len_s;
      err_ovf_r   <= err_ovf_s;
      err_empty_r <= err_empty_s;
    end
  end

endmodule

// File: tb/tb_nmea_fixed_parse.sv
// Directed bench for nmea_fixed_parse: three parameter variants driven from a
// vector table, plus hand-written abort and reset-in-PAD sequences.
module tb_nmea_fixed_parse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        abort_a     [3];
  logic        in_valid_a  [3];
  logic        in_ready_a  [3];
  logic [7:0]  in_data_a   [3];
  logic        in_last_a   [3];
  logic [15:0] value_a     [3];
  logic        out_valid_a [3];
  logic        ec_a        [3];
  logic        el_a        [3];
  logic        eo_a        [3];
  logic        ee_a        [3];

  int checks   = 0;
  int failures = 0;

  // d0: defaults; d1: ROUND=1; d2: FRAC_DIGITS=2
  nmea_fixed_parse #(.FRAC_DIGITS(1), .OUT_W(16), .MAX_CHARS(8), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .in_data(in_data_a[0]), .in_last(in_last_a[0]),
    .value(value_a[0]), .out_valid(out_valid_a[0]), .err_char(ec_a[0]),
    .err_len(el_a[0]), .err_ovf(eo_a[0]), .err_empty(ee_a[0]));

  nmea_fixed_parse #(.FRAC_DIGITS(1), .OUT_W(16), .MAX_CHARS(8), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort_a[1]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .in_data(in_data_a[1]), .in_last(in_last_a[1]),
    .value(value_a[1]), .out_valid(out_valid_a[1]), .err_char(ec_a[1]),
    .err_len(el_a[1]), .err_ovf(eo_a[1]), .err_empty(ee_a[1]));

  nmea_fixed_parse #(.FRAC_DIGITS(2), .OUT_W(16), .MAX_CHARS(8), .ROUND(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .abort(abort_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .in_data(in_data_a[2]), .in_last(in_last_a[2]),
    .value(value_a[2]), .out_valid(out_valid_a[2]), .err_char(ec_a[2]),
    .err_len(el_a[2]), .err_ovf(eo_a[2]), .err_empty(ee_a[2]));

  typedef struct {
    int          dut;
    string       s;
    logic [15:0] val;
    logic [3:0]  errs;  // {char, len, ovf, empty}
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int d, input string s, input logic [15:0] v,
                              input logic [3:0] e, input int l);
    vec_t t;
    t.dut = d; t.s = s; t.val = v; t.errs = e; t.lat = l;
    vq.push_back(t);
  endfunction

  // present one beat and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic beat(input int d, input logic [7:0] c, input logic l);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid_a[d] = 1'b1;
    in_data_a[d]  = c;
    in_last_a[d]  = l;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready_a[d];
      @(posedge clk);
      n++;
    end
    #1;
    in_valid_a[d] = 1'b0;
    in_last_a[d]  = 1'b0;
    if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) beat(d, s[i], 1'b0);
    beat(d, 8'h2C, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int d;
    int lat;
    d = v.dut;
    send_str(d, v.s);
    lat = 1;
    while (!out_valid_a[d] && lat < 10) begin
      check({"pad_ready ", v.s}, {31'd0, in_ready_a[d]}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({"latency ", v.s}, lat, v.lat);
    check({"value ", v.s}, {16'd0, value_a[d]}, {16'd0, v.val});
    check({"errs ", v.s}, {28'd0, ec_a[d], el_a[d], eo_a[d], ee_a[d]}, {28'd0, v.errs});
    @(posedge clk); #1;
    check({"strobe_once ", v.s}, {31'd0, out_valid_a[d]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      abort_a[i] = 1'b0; in_valid_a[i] = 1'b0; in_data_a[i] = 8'h00; in_last_a[i] = 1'b0;
    end
    rst_n = 1'b0;

    add(0, "12.5",      16'd125,   4'b0000, 1);
    add(0, "8.46",      16'd84,    4'b0000, 1);
    add(1, "8.46",      16'd85,    4'b0000, 1);
    add(0, "0.00",      16'd0,     4'b0000, 1);
    add(2, "7",         16'd700,   4'b0000, 3);
    add(2, "3.4",       16'd340,   4'b0000, 2);
    add(0, "1.2.3",     16'd0,     4'b1000, 1);
    add(0, "a5",        16'd0,     4'b1000, 2);
    add(0, "123456789", 16'd0,     4'b0100, 2);
    add(0, "12345678",  16'd65535, 4'b0010, 2);
    add(0, "9999",      16'd65535, 4'b0010, 2);
    add(0, "6553.5",    16'd65535, 4'b0000, 1);
    add(0, "6553.6",    16'd65535, 4'b0010, 1);
    add(1, "9.95",      16'd100,   4'b0000, 1);
    add(1, "6553.55",   16'd65535, 4'b0010, 1);
    add(0, "",          16'd0,     4'b0001, 1);
    add(0, "",          16'd0,     4'b0001, 1);
    add(0, ".",         16'd0,     4'b0001, 1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready_a[0]}, 32'd0);
    check("rst_value", {16'd0, value_a[0]}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
    check("rst_errs", {28'd0, ec_a[0], el_a[0], eo_a[0], ee_a[0]}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready_a[0]}, 32'd1);

    foreach (vq[i]) run_vec(vq[i]);

    // abort after "45" wins over a simultaneous terminator beat
    beat(0, 8'h34, 1'b0);
    beat(0, 8'h35, 1'b0);
    abort_a[0] = 1'b1; in_valid_a[0] = 1'b1; in_data_a[0] = 8'h36; in_last_a[0] = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, in_ready_a[0]}, 32'd0);
    @(posedge clk); #1;
    abort_a[0] = 1'b0; in_valid_a[0] = 1'b0; in_last_a[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", {31'd0, out_valid_a[0]}, 32'd0);
      @(posedge clk); #1;
    end
    begin
      vec_t t;
      t.dut = 0; t.s = "3.1"; t.val = 16'd31; t.errs = 4'b0000; t.lat = 1;
      run_vec(t);
    end

    // reset while in PAD drops the field
    send_str(2, "7");
    check("pad_ready_before_rst", {31'd0, in_ready_a[2]}, 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_pad_no_valid", {31'd0, out_valid_a[2]}, 32'd0);
      check("rst_pad_ready", {31'd0, in_ready_a[2]}, 32'd0);
    end
    check("rst_pad_value", {16'd0, value_a[2]}, 32'd0);
    check("rst_pad_errs", {28'd0, ec_a[2], el_a[2], eo_a[2], ee_a[2]}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_pad_ready_after", {31'd0, in_ready_a[2]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_pad_quiet", {31'd0, out_valid_a[2]}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nmea_fixed_parse.md
NMEA_FIXED_PARSE -- requirements
Module: nmea_fixed_parse

Interface
REQ-001 The module SHALL have parameters (name, default, meaning):
  - FRAC_DIGITS, 1: decimal digits kept after the point; output = value*10^FRAC_DIGITS.
  - OUT_W, 16: output width, unsigned.
  - MAX_CHARS, 8: maximum accepted characters per field, including '.'.
  - ROUND, 0: 0 = truncate extra fraction digits; 1 = round half-up on the first dropped digit.
REQ-002 The module SHALL have one clock; reset is synchronous and active-low. Ports (name, direction, width, meaning):
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  synchronous active-low reset.
  - abort  in  1  pulse that discards the current field, e.g. on '$'.
  - in_valid  in  1  character beat present.
  - in_ready  out  1  beat accepted when in_valid && in_ready.
  - in_data  in  8  ASCII character; ignored on a last beat.
  - in_last  in  1  beat is the field terminator (',' or '*'); it carries no character.
  - value  out  OUT_W  scaled result, held until the next result.
  - out_valid  out  1  one-cycle result strobe.
  - err_char  out  1  illegal character or second '.'; valid with out_valid.
  - err_len  out  1  more than MAX_CHARS characters; valid with out_valid.
  - err_ovf  out  1  result saturated; valid with out_valid.
  - err_empty  out  1  field contained no digits; valid with out_valid.

Function
REQ-003 The FSM SHALL have five states: IDLE, INT, FRAC, PAD, FINAL.
REQ-004 In IDLE, INT and FRAC, in_ready SHALL be 1 unless abort=1. In PAD and FINAL, in_ready SHALL be 0.
REQ-005 First accepted beat: a digit or '.' moves IDLE to INT or FRAC respectively. A last beat goes to FINAL.
REQ-006 In INT, a digit d SHALL update acc = acc*10 + d. A '.' moves to FRAC.
REQ-007 In FRAC, a digit SHALL be accumulated only while frac_cnt < FRAC_DIGITS, incrementing frac_cnt. The first digit beyond that SHALL be stored as rnd_digit; later digits SHALL be ignored, but still counted toward length.
REQ-008 Any character other than '0'-'9' or '.', or a '.' while in FRAC, SHALL set sticky err_char. Parsing continues until in_last.
REQ-009 Each accepted non-last beat SHALL increment char_cnt. Once char_cnt exceeds MAX_CHARS, err_len SHALL be set and further characters ignored.
REQ-010 On a last beat in INT or FRAC: if frac_cnt < FRAC_DIGITS, the FSM goes to PAD, else to FINAL.
REQ-011 PAD SHALL perform acc = acc*10 once per cycle until frac_cnt == FRAC_DIGITS, then go to FINAL.
  - Latency from the last beat to out_valid = (FRAC_DIGITS - frac_cnt) + 1 cycles.
REQ-012 FINAL SHALL last one cycle, then return to IDLE, and SHALL:
  - if ROUND=1 and rnd_digit >= 5, add 1 to acc;
  - drive value and all err_* for that cycle's result;
  - pulse out_valid.
REQ-013 Value selection in FINAL SHALL follow this order:
  - err_char or err_len set: value = 0;
  - otherwise, acc > 2^OUT_W-1: value = 2^OUT_W-1 and err_ovf = 1;
  - otherwise: value = acc.
REQ-014 The accumulator SHALL be OUT_W+4 bits. Once it exceeds 2^OUT_W-1, it SHALL hold a sticky overflow flag and stop growing, so it never wraps.
REQ-015 A last beat with zero digits seen (e.g. ",," or ".,") SHALL give value = 0 and err_empty = 1, with no PAD cycles.
REQ-016 abort=1 in any state SHALL return the FSM to IDLE next cycle and clear acc, counters and flags. No out_valid results. abort SHALL win over a simultaneous beat, which is not consumed.
REQ-017 err_* flags SHALL be cleared on entry to a new field, i.e. the first accepted beat from IDLE.

Reset
REQ-018 With rst_n=0 at a rising edge, the module SHALL set:
  - FSM = IDLE; acc, frac_cnt, char_cnt, rnd_digit = 0;
  - value = 0; out_valid = 0; all err_* = 0;
  - in_ready = 0 during reset and 1 in the first cycle after rst_n=1.
REQ-019 Reset mid-field or mid-PAD SHALL drop the field with no out_valid.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults unless stated):
  - "12.5", in_last -> value=125, out_valid exactly 1 cycle after the last beat, no errors.
  - "8.46": ROUND=0 -> 84; ROUND=1 -> 85. "0.00" -> 0.
  - "7", FRAC_DIGITS=2 -> two PAD cycles with in_ready=0, then value=700; out_valid 3 cycles after the last beat.
  - "1.2.3" -> value=0, err_char=1. "123456789" with MAX_CHARS=8 -> value=0, err_len=1.
  - "9999" with OUT_W=16 (raw 99990 > 65535) -> value=65535, err_ovf=1.
  - ",," empty field -> value=0, err_empty=1.
  - abort asserted after "45" -> no out_valid; the next field "3.1" -> 31 with all flags clear.
  - rst_n=0 during PAD -> no out_valid, all outputs 0.
